decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 264 ++++++++++++++++++++++++++
 tb/tb_decode_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pipe
//  Purpose  : Instruction queue, combinational head decode, scoreboard-based
//             read-hazard stall, registered issue stage and syscall hold FSM.
//  Revision : 1.0  initial release
// ============================================================================
module decode_pipe #(
    parameter int W_CPU = 32,
    parameter int W_REG = 5,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W_CPU-1:0]       in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W_REG-1:0]       wa,
    output logic [W_REG-1:0]       ra1,
    output logic [W_REG-1:0]       ra2,
    output logic                   reg_wen,
    output logic                   imm_ext,
    output logic                   illegal,
    output logic [15:0]            imm,
    output logic [5:0]             alu_op,
    output logic [1:0]             alu_src,
    input  logic                   wb_valid,
    input  logic [W_REG-1:0]       wb_addr,
    input  logic                   flush,
    input  logic                   resume,
    output logic [(1<<W_REG)-1:0]  busy
);

    localparam int NREG = 1 << W_REG;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    localparam logic [CW-1:0]    c_DEPTH    = CW'(DEPTH);
    localparam logic [1:0]       c_SRC_REG  = 2'd0;
    localparam logic [1:0]       c_SRC_IMM  = 2'd1;
    localparam logic [1:0]       c_SRC_SHA  = 2'd2;
    localparam logic [W_REG-1:0] c_REG_A0   = W_REG'(4);
    localparam logic [W_REG-1:0] c_REG_V0   = W_REG'(2);

    localparam logic [5:0] c_OP_RTYPE = 6'h00, c_OP_ADDI = 6'h08, c_OP_ADDIU = 6'h09,
                           c_OP_SLTI  = 6'h0a, c_OP_SLTIU = 6'h0b, c_OP_ANDI = 6'h0c,
                           c_OP_ORI   = 6'h0d, c_OP_XORI = 6'h0e;
    localparam logic [5:0] c_FN_SLL  = 6'h00, c_FN_SRL  = 6'h02, c_FN_SYSCALL = 6'h0c,
                           c_FN_ADD  = 6'h20, c_FN_ADDU = 6'h21, c_FN_SUB = 6'h22,
                           c_FN_SUBU = 6'h23, c_FN_AND  = 6'h24, c_FN_OR  = 6'h25,
                           c_FN_NOR  = 6'h27, c_FN_SLT  = 6'h2a, c_FN_SLTU = 6'h2b;

    typedef enum logic [0:0] {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

    state_t            r_state, w_state_next;
    logic [W_CPU-1:0]  r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [NREG-1:0]   r_busy, w_busy_next;
    logic              r_out_valid;
    logic [W_REG-1:0]  r_wa, r_ra1, r_ra2;
    logic              r_wen, r_ext, r_ill;
    logic [15:0]       r_imm;
    logic [5:0]        r_op;
    logic [1:0]        r_src;

    logic              w_push, w_load, w_empty, w_full, w_stall;
    logic [W_CPU-1:0]  w_head;
    logic [5:0]        w_opcode, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_sh;
    logic [W_REG-1:0]  w_d_wa, w_d_ra1, w_d_ra2;
    logic              w_d_wen, w_d_ext, w_d_ill, w_d_use1, w_d_use2, w_d_sys;
    logic [15:0]       w_d_imm;
    logic [5:0]        w_d_op;
    logic [1:0]        w_d_src;

    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full && !flush;
    assign w_push   = in_valid && in_ready;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_opcode = w_head[31:26];
    assign w_rs     = w_head[25:21];
    assign w_rt     = w_head[20:16];
    assign w_rd     = w_head[15:11];
    assign w_sh     = w_head[10:6];
    assign w_funct  = w_head[5:0];

    // Queue storage write; contents need no reset since occupancy gates use
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_inst;
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_load) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head decode; anything not recognised falls through as illegal with zero fields
    always_comb begin
        w_d_wa   = '0;
        w_d_ra1  = '0;
        w_d_ra2  = '0;
        w_d_wen  = 1'b0;
        w_d_ext  = 1'b0;
        w_d_ill  = 1'b0;
        w_d_imm  = '0;
        w_d_op   = '0;
        w_d_src  = c_SRC_REG;
        w_d_use1 = 1'b0;
        w_d_use2 = 1'b0;
        w_d_sys  = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_FN_ADD, c_FN_ADDU, c_FN_SUB, c_FN_SUBU, c_FN_AND,
                    c_FN_OR, c_FN_NOR, c_FN_SLT, c_FN_SLTU: begin
                        w_d_wa   = W_REG'(w_rd);
                        w_d_ra1  = W_REG'(w_rs);
                        w_d_ra2  = W_REG'(w_rt);
                        w_d_wen  = 1'b1;
                        w_d_use1 = 1'b1;
                        w_d_use2 = 1'b1;
                        w_d_op   = w_funct;
                    end
                    c_FN_SLL, c_FN_SRL: begin
                        // shift amount travels on ra2 but is not a register read
                        w_d_wa   = W_REG'(w_rd);
                        w_d_ra1  = W_REG'(w_rt);
                        w_d_ra2  = W_REG'(w_sh);
                        w_d_src  = c_SRC_SHA;
                        w_d_wen  = 1'b1;
                        w_d_use1 = 1'b1;
                        w_d_op   = w_funct;
                    end
                    c_FN_SYSCALL: begin
                        w_d_ra1  = c_REG_A0;
                        w_d_ra2  = c_REG_V0;
                        w_d_use1 = 1'b1;
                        w_d_use2 = 1'b1;
                        w_d_sys  = 1'b1;
                        w_d_op   = w_funct;
                    end
                    default: w_d_ill = 1'b1;
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
            c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                w_d_wa   = W_REG'(w_rt);
                w_d_ra1  = W_REG'(w_rs);
                w_d_src  = c_SRC_IMM;
                w_d_imm  = w_head[15:0];
                w_d_wen  = 1'b1;
                w_d_use1 = 1'b1;
                w_d_op   = w_opcode;
                w_d_ext  = (w_opcode == c_OP_ADDI) || (w_opcode == c_OP_ADDIU) ||
                           (w_opcode == c_OP_SLTI) || (w_opcode == c_OP_SLTIU);
            end
            default: w_d_ill = 1'b1;
        endcase
    end

    assign w_stall = (w_d_use1 && (w_d_ra1 != '0) && r_busy[w_d_ra1]) ||
                     (w_d_use2 && (w_d_ra2 != '0) && r_busy[w_d_ra2]);
    assign w_load  = !w_empty && !w_stall && (!r_out_valid || out_ready) &&
                     (r_state == S_RUN) && !flush;

    // Scoreboard update: writeback clear first so a same-edge issue set wins
    always_comb begin
        w_busy_next = r_busy;
        if (wb_valid) w_busy_next[wb_addr] = 1'b0;
        if (w_load && w_d_wen && (w_d_wa != '0)) w_busy_next[w_d_wa] = 1'b1;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_next;
    end

    // Syscall hold state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_state_next;
    end

    // Hold is entered when a syscall issues and left on resume or flush
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_load && w_d_sys) w_state_next = S_HOLD;
                S_HOLD:  if (resume) w_state_next = S_RUN;
                default: w_state_next = S_RUN;
            endcase
        end
    end

    // Issue register; fields only change on load so they hold while stalled downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_wa  <= '0;
            r_ra1 <= '0;
            r_ra2 <= '0;
            r_wen <= 1'b0;
            r_ext <= 1'b0;
            r_ill <= 1'b0;
            r_imm <= '0;
            r_op  <= '0;
            r_src <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_wa  <= w_d_wa;
            r_ra1 <= w_d_ra1;
            r_ra2 <= w_d_ra2;
            r_wen <= w_d_wen;
            r_ext <= w_d_ext;
            r_ill <= w_d_ill;
            r_imm <= w_d_imm;
            r_op  <= w_d_op;
            r_src <= w_d_src;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign wa        = r_wa;
    assign ra1       = r_ra1;
    assign ra2       = r_ra2;
    assign reg_wen   = r_wen;
    assign imm_ext   = r_ext;
    assign illegal   = r_ill;
    assign imm       = r_imm;
    assign alu_op    = r_op;
    assign alu_src   = r_src;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_pipe
//  Purpose  : Directed and random stimulus for decode_pipe against a
//             queue-based cycle reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_pipe;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [4:0]  wa, ra1, ra2, wb_addr;
    logic        reg_wen, imm_ext, illegal, wb_valid, flush, resume;
    logic [15:0] imm;
    logic [5:0]  alu_op;
    logic [1:0]  alu_src;
    logic [31:0] busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    decode_pipe #(.W_CPU(32), .W_REG(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .wa(wa), .ra1(ra1), .ra2(ra2),
        .reg_wen(reg_wen), .imm_ext(imm_ext), .illegal(illegal),
        .imm(imm), .alu_op(alu_op), .alu_src(alu_src),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .flush(flush), .resume(resume), .busy(busy)
    );

    typedef struct packed {
        logic [4:0]  wa, ra1, ra2;
        logic        wen, ext, ill, use1, use2, sys;
        logic [15:0] imm;
        logic [5:0]  op;
        logic [1:0]  src;
    } dec_t;

    // reference model state
    logic [31:0] mq[$];
    bit          mov;
    logic [31:0] mout;
    logic [31:0] mbusy;
    bit          mhold;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    // instruction semantics straight from the mnemonic table
    function automatic dec_t ref_dec(input logic [31:0] i);
        dec_t d;
        logic [5:0] op, fn;
        d  = '0;
        op = i[31:26];
        fn = i[5:0];
        if (op == 6'h00 && fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b}) begin
            d.wa = i[15:11]; d.ra1 = i[25:21]; d.ra2 = i[20:16];
            d.wen = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; d.op = fn; d.src = 2'd0;
        end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02)) begin
            d.wa = i[15:11]; d.ra1 = i[20:16]; d.ra2 = i[10:6];
            d.wen = 1'b1; d.use1 = 1'b1; d.op = fn; d.src = 2'd2;
        end else if (op == 6'h00 && fn == 6'h0c) begin
            d.ra1 = 5'd4; d.ra2 = 5'd2; d.use1 = 1'b1; d.use2 = 1'b1; d.sys = 1'b1; d.op = fn;
        end else if (op inside {[6'h08:6'h0e]}) begin
            d.wa = i[20:16]; d.ra1 = i[25:21]; d.imm = i[15:0];
            d.wen = 1'b1; d.use1 = 1'b1; d.op = op; d.src = 2'd1;
            d.ext = (op <= 6'h0b);
        end else begin
            d.ill = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_inst();
        int unsigned k = $urandom_range(0, 15);
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        logic [4:0] rd = 5'($urandom_range(0, 7));
        logic [5:0] fn;
        if (k <= 4) begin
            case ($urandom_range(0, 8))
                0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h23; 4: fn = 6'h24;
                5: fn = 6'h25; 6: fn = 6'h27; 7: fn = 6'h2a; default: fn = 6'h2b;
            endcase
            return enc_r(fn, rs, rt, rd, 5'd0);
        end else if (k == 5) begin
            return enc_r(($urandom_range(0, 1) == 0) ? 6'h00 : 6'h02, 5'd0, rt, rd, 5'($urandom));
        end else if (k == 6) begin
            return enc_r(6'h0c, 5'd0, 5'd0, 5'd0, 5'd0);
        end else if (k <= 12) begin
            return enc_i(6'($urandom_range(8, 14)), rs, rt, 16'($urandom));
        end else if (k == 13) begin
            return enc_r(($urandom_range(0, 1) == 0) ? 6'h26 : 6'h3f, rs, rt, rd, 5'd0);
        end else begin
            return {6'($urandom_range(15, 63)), 26'($urandom)};
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        dec_t e;
        chk("out_valid", 64'(out_valid), 64'(mov));
        chk("busy", 64'(busy), 64'(mbusy));
        if (mov) begin
            e = ref_dec(mout);
            chk("wa", 64'(wa), 64'(e.wa));
            chk("ra1", 64'(ra1), 64'(e.ra1));
            chk("ra2", 64'(ra2), 64'(e.ra2));
            chk("reg_wen", 64'(reg_wen), 64'(e.wen));
            chk("imm_ext", 64'(imm_ext), 64'(e.ext));
            chk("illegal", 64'(illegal), 64'(e.ill));
            chk("imm", 64'(imm), 64'(e.imm));
            chk("alu_op", 64'(alu_op), 64'(e.op));
            chk("alu_src", 64'(alu_src), 64'(e.src));
        end
    endtask

    // one clock: inputs already driven; predict, clock, compare
    task automatic cycle();
        bit          exp_rdy, acc, ld, stall;
        dec_t        h;
        logic [31:0] head, nb;
        #1;
        exp_rdy = (mq.size() < DEPTH) && !flush;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc   = in_valid && exp_rdy;
        ld    = 1'b0;
        stall = 1'b0;
        h     = '0;
        head  = '0;
        if (mq.size() > 0) begin
            head  = mq[0];
            h     = ref_dec(head);
            stall = (h.use1 && h.ra1 != 0 && mbusy[h.ra1]) || (h.use2 && h.ra2 != 0 && mbusy[h.ra2]);
            ld    = !flush && !stall && (!mov || out_ready) && !mhold;
        end
        nb = mbusy;
        if (wb_valid) nb[wb_addr] = 1'b0;
        if (ld && h.wen && h.wa != 0) nb[h.wa] = 1'b1;
        if (flush)               mhold = 1'b0;
        else if (ld && h.sys)    mhold = 1'b1;
        else if (mhold && resume) mhold = 1'b0;
        if (flush) begin
            mq.delete();
            mov = 1'b0;
        end else begin
            if (ld) void'(mq.pop_front());
            if (acc) mq.push_back(in_inst);
            if (ld) begin
                mov  = 1'b1;
                mout = head;
            end else if (out_ready) begin
                mov = 1'b0;
            end
        end
        mbusy = nb;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic quiet();
        in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fields", 64'({wa, ra1, ra2, reg_wen, imm_ext, illegal, imm, alu_op, alu_src}), 64'd0);
        mq.delete(); mov = 1'b0; mout = '0; mbusy = '0; mhold = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_reg(input logic [4:0] r);
        wb_valid = 1'b1; wb_addr = r;
        cycle();
        wb_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] b0;
        rst_n = 1'b0; in_inst = '0; out_ready = 1'b1; wb_addr = '0;
        quiet();
        do_reset();

        // RAW hazard on $8: ADDI then ADD
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = enc_i(6'h08, 5'd0, 5'd8, 16'hfff8);
        cycle();
        in_inst = enc_r(6'h20, 5'd8, 5'd8, 5'd9, 5'd0);
        cycle();
        in_valid = 1'b0;
        chk("raw_addi_wa", 64'(wa), 64'd8);
        chk("raw_addi_ext", 64'(imm_ext), 64'd1);
        chk("raw_busy8", 64'(busy[8]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("raw_stalled", 64'(out_valid), 64'd0);
        end
        clear_reg(5'd8);
        chk("raw_wb_edge", 64'(out_valid), 64'd0);
        cycle();
        chk("raw_add_valid", 64'(out_valid), 64'd1);
        chk("raw_add_wa", 64'(wa), 64'd9);
        clear_reg(5'd9);

        // fill to full with the output blocked, then drain in order
        out_ready = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            in_valid = 1'b1; in_inst = enc_i(6'h0d, 5'd0, 5'(k), 16'(k));
            cycle();
        end
        in_inst = enc_i(6'h0d, 5'd0, 5'd7, 16'd7);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cycle();
        cycle();
        chk("full_head_wa", 64'(wa), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            chk("drain_order", 64'(wa), 64'(k));
            cycle();
        end
        for (int k = 1; k <= DEPTH + 1; k++) clear_reg(5'(k));

        // illegal opcode
        b0 = busy;
        in_valid = 1'b1; in_inst = 32'hfc00_1234;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("ill_flag", 64'(illegal), 64'd1);
        chk("ill_wen", 64'(reg_wen), 64'd0);
        chk("ill_busy", 64'(busy), 64'(b0));

        // syscall hold
        in_valid = 1'b1; in_inst = enc_r(6'h0c, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle();
        in_inst = enc_i(6'h0d, 5'd1, 5'd3, 16'h00ff);
        cycle();
        in_valid = 1'b0;
        chk("sys_ra1", 64'(ra1), 64'd4);
        chk("sys_ra2", 64'(ra2), 64'd2);
        chk("sys_wen", 64'(reg_wen), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("sys_held", 64'(out_valid), 64'd0);
        end
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        cycle();
        chk("sys_ori_valid", 64'(out_valid), 64'd1);
        chk("sys_ori_wa", 64'(wa), 64'd3);
        clear_reg(5'd3);

        // flush with two queued and a same-cycle writeback
        out_ready = 1'b0;
        for (int k = 9; k <= 11; k++) begin
            in_valid = 1'b1; in_inst = enc_i(6'h08, 5'd0, 5'(k), 16'd1);
            cycle();
        end
        in_valid = 1'b0;
        chk("fl_busy9_pre", 64'(busy[9]), 64'd1);
        flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd9;
        cycle();
        flush = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_busy9", 64'(busy[9]), 64'd0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("fl_empty", 64'(out_valid), 64'd0);
        end

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
        cycle();
        for (int k = 12; k <= 14; k++) begin
            in_inst = enc_i(6'h0d, 5'd0, 5'(k), 16'd2);
            cycle();
        end
        in_valid = 1'b0;
        chk("rst_pre_busy8", 64'(busy[8]), 64'd1);
        do_reset();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_inst   = rand_inst();
            out_ready = ($urandom_range(0, 9) < 7);
            wb_valid  = ($urandom_range(0, 1) == 1);
            wb_addr   = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 29) == 0);
            resume    = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
